i2s_rx_sync: RTL and testbench

I2S_RX_SYNC -- requirements
Module: i2s_rx_sync

---
 rtl/i2s_rx_sync.sv | 158 +++++++++++++++
 tb/tb_i2s_rx_sync.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_sync.sv
// I2S receiver: synchronizes sck/ws/sd into clk, assembles left/right words
// and presents complete stereo frames on l/r with a valid/ready handshake.
module i2s_rx_sync #(
  parameter int b    = 16,
  parameter int mode = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sck,
  input  logic         ws,
  input  logic         sd,
  output logic [b-1:0] l,
  output logic [b-1:0] r,
  output logic         valid,
  input  logic         ready,
  output logic         ovf
);

  // Handshake: a frame on l/r is transferred in every clk where valid && ready;
  // valid and l/r never change while valid=1 and ready=0.

  localparam logic [b-1:0] msb_bit = ~({b{1'b1}} >> 1);

  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic ws_s1_q, ws_s2_q;
  logic sd_s1_q, sd_s2_q;

  logic         ws_prev_q, ws_prev_d;
  logic         seen_q, seen_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [b-1:0] word_q, word_d;
  logic [b-1:0] left_q, left_d;
  logic         lpend_q, lpend_d;
  logic [b-1:0] l_q, l_d;
  logic [b-1:0] r_q, r_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;

  logic         sck_rise;
  logic         ws_edge;
  logic [b-1:0] word_app;
  logic [5:0]   cnt_inc;
  logic [b-1:0] commit_word;
  logic         commit_left;
  logic         commit_right;

  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign ws_edge  = ws_s2_q ^ ws_prev_q;

  // Bits past position 0 shift out of msb_bit and are silently discarded.
  assign word_app = sd_s2_q ? (word_q | (msb_bit >> cnt_q)) : word_q;
  assign cnt_inc  = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

  always_comb begin
    ws_prev_d    = ws_prev_q;
    seen_d       = seen_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    left_d       = left_q;
    lpend_d      = lpend_q;
    l_d          = l_q;
    r_d          = r_q;
    valid_d      = valid_q;
    ovf_d        = ovf_q;
    commit_word  = word_q;
    commit_left  = 1'b0;
    commit_right = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    if (sck_rise) begin
      ws_prev_d = ws_s2_q;
      if (!ws_edge) begin
        word_d = word_app;
        cnt_d  = cnt_inc;
      end else begin
        seen_d = 1'b1;
        // Philips: the bit sampled on the WS edge is still the old word's LSB.
        if (mode == 0) begin
          commit_word = word_app;
          word_d      = '0;
          cnt_d       = 6'd0;
        end else begin
          commit_word = word_q;
          word_d      = sd_s2_q ? msb_bit : '0;
          cnt_d       = 6'd1;
        end
        commit_left  = seen_q & ~ws_prev_q;
        commit_right = seen_q & ws_prev_q;
      end
    end

    if (commit_left) begin
      left_d  = commit_word;
      lpend_d = 1'b1;
    end

    // A right word without a pending left word is an orphan and is dropped.
    if (commit_right && lpend_q) begin
      lpend_d = 1'b0;
      if (!valid_q || ready) begin
        l_d     = left_q;
        r_d     = commit_word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      ws_s1_q    <= 1'b0;
      ws_s2_q    <= 1'b0;
      sd_s1_q    <= 1'b0;
      sd_s2_q    <= 1'b0;
      ws_prev_q  <= 1'b0;
      seen_q     <= 1'b0;
      cnt_q      <= 6'd0;
      word_q     <= '0;
      left_q     <= '0;
      lpend_q    <= 1'b0;
      l_q        <= '0;
      r_q        <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sck_s1_q   <= sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      ws_s1_q    <= ws;
      ws_s2_q    <= ws_s1_q;
      sd_s1_q    <= sd;
      sd_s2_q    <= sd_s1_q;
      ws_prev_q  <= ws_prev_d;
      seen_q     <= seen_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      left_q     <= left_d;
      lpend_q    <= lpend_d;
      l_q        <= l_d;
      r_q        <= r_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign l     = l_q;
  assign r     = r_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_i2s_rx_sync.sv
// Directed bench for i2s_rx_sync: three instances (b=16/mode0, b=24/mode1,
// b=32/mode0) share one serial bus; each scenario checks the relevant one.
`timescale 1ns/1ps
module tb_i2s_rx_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sck = 1'b0;
  logic ws = 1'b0;
  logic sd = 1'b0;
  logic ready = 1'b0;

  logic [15:0] l0, r0;
  logic        valid0, ovf0;
  logic [23:0] l1, r1;
  logic        valid1, ovf1;
  logic [31:0] l2, r2;
  logic        valid2, ovf2;

  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_lsb = 1'b0;
  time  t_rise = 0;
  time  lat0 = 0;
  int   run0 = 0;
  int   max_run0 = 0;
  logic valid0_prev = 1'b0;

  logic [15:0] got_l0[$], got_r0[$];
  logic [23:0] got_l1[$], got_r1[$];
  logic [31:0] got_l2[$], got_r2[$];

  i2s_rx_sync #(.b(16), .mode(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
    .l(l0), .r(r0), .valid(valid0), .ready(ready), .ovf(ovf0));
  i2s_rx_sync #(.b(24), .mode(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
    .l(l1), .r(r1), .valid(valid1), .ready(ready), .ovf(ovf1));
  i2s_rx_sync #(.b(32), .mode(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
    .l(l2), .r(r2), .valid(valid2), .ready(ready), .ovf(ovf2));

  // clock / reset
  always #5 clk = ~clk;

  // accepted-frame monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (valid0 && ready) begin
      got_l0.push_back(l0);
      got_r0.push_back(r0);
    end
    if (valid1 && ready) begin
      got_l1.push_back(l1);
      got_r1.push_back(r1);
    end
    if (valid2 && ready) begin
      got_l2.push_back(l2);
      got_r2.push_back(r2);
    end
    if (valid0 && !valid0_prev) lat0 = $time - t_rise;
    run0 = valid0 ? run0 + 1 : 0;
    if (run0 > max_run0) max_run0 = run0;
    valid0_prev = valid0;
  end

  task automatic clear_monitors();
    got_l0.delete(); got_r0.delete();
    got_l1.delete(); got_r1.delete();
    got_l2.delete(); got_r2.delete();
    run0 = 0;
    max_run0 = 0;
    lat0 = 1000000;
  endtask

  task automatic do_reset();
    sck = 1'b0; ws = 1'b0; sd = 1'b0; prev_lsb = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    clear_monitors();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ready changes just after a rising edge so monitor and DUT see the same value
  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 ready = v;
  endtask

  // driver tasks
  task automatic send_bit(input logic w, input logic d);
    ws = w;
    sd = d;
    #80 sck = 1'b1;
    t_rise = $time;
    #80 sck = 1'b0;
  endtask

  // mode 0 slots carry the previous word's LSB in their first bit period
  task automatic send_word(input logic w, input logic [69:0] word, input int nbits, input int md);
    if (md == 0) begin
      send_bit(w, prev_lsb);
      for (int i = nbits - 1; i >= 1; i--) send_bit(w, word[i]);
      prev_lsb = word[0];
    end else begin
      for (int i = nbits - 1; i >= 0; i--) send_bit(w, word[i]);
    end
  endtask

  task automatic send_part(input logic w, input int n);
    for (int i = 0; i < n; i++) send_bit(w, 1'($urandom_range(0, 1)));
    prev_lsb = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (l0 !== 16'h0) $display("FAIL reset_l: got %h want 0000", l0); else n_pass++;
    n_checks++; if (r0 !== 16'h0) $display("FAIL reset_r: got %h want 0000", r0); else n_pass++;
    n_checks++; if (valid0 !== 1'b0) $display("FAIL reset_valid0: got %b want 0", valid0); else n_pass++;
    n_checks++; if (ovf0 !== 1'b0) $display("FAIL reset_ovf0: got %b want 0", ovf0); else n_pass++;
    n_checks++; if (valid1 !== 1'b0) $display("FAIL reset_valid1: got %b want 0", valid1); else n_pass++;
    n_checks++; if (valid2 !== 1'b0) $display("FAIL reset_valid2: got %b want 0", valid2); else n_pass++;
    do_reset();
  endtask

  task automatic test_philips_basic();
    do_reset();
    set_ready(1'b1);
    send_word(1'b1, 70'h0, 32, 0);
    send_word(1'b0, 70'h1234_5678, 32, 0);
    send_word(1'b1, 70'h9ABC_DEF0, 32, 0);
    send_part(1'b0, 4);
    repeat (8) @(negedge clk);
    n_checks++; if (got_l0.size() !== 1) $display("FAIL basic_count: got %0d want 1", got_l0.size()); else n_pass++;
    if (got_l0.size() > 0) begin
      n_checks++; if (got_l0[0] !== 16'h1234) $display("FAIL basic_l: got %h want 1234", got_l0[0]); else n_pass++;
      n_checks++; if (got_r0[0] !== 16'h9ABC) $display("FAIL basic_r: got %h want 9abc", got_r0[0]); else n_pass++;
    end
    n_checks++; if (max_run0 !== 1) $display("FAIL basic_pulse: got %0d cycles want 1", max_run0); else n_pass++;
    n_checks++; if (lat0 > 80) $display("FAIL basic_latency: got %0t want <= 80ns", lat0); else n_pass++;
    n_checks++; if (ovf0 !== 1'b0) $display("FAIL basic_ovf: got %b want 0", ovf0); else n_pass++;
    n_checks++; if (valid0 !== 1'b0) $display("FAIL basic_valid_end: got %b want 0", valid0); else n_pass++;
  endtask

  task automatic test_left_justified();
    do_reset();
    set_ready(1'b1);
    send_word(1'b1, 70'h0F0F, 16, 1);
    send_word(1'b0, 70'hA5A5, 16, 1);
    send_word(1'b1, 70'h0001, 16, 1);
    send_part(1'b0, 4);
    repeat (8) @(negedge clk);
    n_checks++; if (got_l1.size() !== 1) $display("FAIL lj_count: got %0d want 1", got_l1.size()); else n_pass++;
    if (got_l1.size() > 0) begin
      n_checks++; if (got_l1[0] !== 24'hA5A500) $display("FAIL lj_l: got %h want a5a500", got_l1[0]); else n_pass++;
      n_checks++; if (got_r1[0] !== 24'h000100) $display("FAIL lj_r: got %h want 000100", got_r1[0]); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    set_ready(1'b0);
    send_word(1'b1, 70'h0, 32, 0);
    send_word(1'b0, 70'hCAFE_1111, 32, 0);
    send_word(1'b1, 70'hBEEF_2222, 32, 0);
    send_word(1'b0, 70'h1357_3333, 32, 0);
    send_word(1'b1, 70'h2468_4444, 32, 0);
    send_part(1'b0, 4);
    repeat (8) @(negedge clk);
    n_checks++; if (valid0 !== 1'b1) $display("FAIL ovf_valid_held: got %b want 1", valid0); else n_pass++;
    n_checks++; if (l0 !== 16'hCAFE) $display("FAIL ovf_l_held: got %h want cafe", l0); else n_pass++;
    n_checks++; if (r0 !== 16'hBEEF) $display("FAIL ovf_r_held: got %h want beef", r0); else n_pass++;
    n_checks++; if (ovf0 !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf0); else n_pass++;
    n_checks++; if (got_l0.size() !== 0) $display("FAIL ovf_no_accept: got %0d want 0", got_l0.size()); else n_pass++;
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (valid0 !== 1'b0) $display("FAIL ovf_valid_clear: got %b want 0", valid0); else n_pass++;
    n_checks++; if (ovf0 !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf0); else n_pass++;
    n_checks++; if (got_l0.size() !== 1) $display("FAIL ovf_accept_count: got %0d want 1", got_l0.size()); else n_pass++;
    if (got_l0.size() > 0) begin
      n_checks++; if (got_l0[0] !== 16'hCAFE) $display("FAIL ovf_accept_l: got %h want cafe", got_l0[0]); else n_pass++;
      n_checks++; if (got_r0[0] !== 16'hBEEF) $display("FAIL ovf_accept_r: got %h want beef", got_r0[0]); else n_pass++;
    end
  endtask

  task automatic test_mid_stream();
    // stream picked up partway through a right word
    do_reset();
    set_ready(1'b1);
    send_part(1'b1, 10);
    send_word(1'b0, 70'h55AA_0000, 32, 0);
    send_word(1'b1, 70'h0FF0_0000, 32, 0);
    send_word(1'b0, 70'h8001_0000, 32, 0);
    send_word(1'b1, 70'h7FFE_0000, 32, 0);
    send_part(1'b0, 4);
    repeat (8) @(negedge clk);
    n_checks++; if (got_l0.size() !== 2) $display("FAIL midr_count: got %0d want 2", got_l0.size()); else n_pass++;
    if (got_l0.size() > 1) begin
      n_checks++; if (got_l0[0] !== 16'h55AA) $display("FAIL midr_l0: got %h want 55aa", got_l0[0]); else n_pass++;
      n_checks++; if (got_r0[0] !== 16'h0FF0) $display("FAIL midr_r0: got %h want 0ff0", got_r0[0]); else n_pass++;
      n_checks++; if (got_l0[1] !== 16'h8001) $display("FAIL midr_l1: got %h want 8001", got_l0[1]); else n_pass++;
      n_checks++; if (got_r0[1] !== 16'h7FFE) $display("FAIL midr_r1: got %h want 7ffe", got_r0[1]); else n_pass++;
    end
    // stream picked up partway through a left word, followed by an orphan right word
    do_reset();
    set_ready(1'b1);
    send_part(1'b0, 10);
    send_word(1'b1, 70'hFFFF_FFFF, 32, 0);
    send_word(1'b0, 70'h3C3C_0000, 32, 0);
    send_word(1'b1, 70'hC3C3_0000, 32, 0);
    send_part(1'b0, 4);
    repeat (8) @(negedge clk);
    n_checks++; if (got_l0.size() !== 1) $display("FAIL midl_count: got %0d want 1", got_l0.size()); else n_pass++;
    if (got_l0.size() > 0) begin
      n_checks++; if (got_l0[0] !== 16'h3C3C) $display("FAIL midl_l: got %h want 3c3c", got_l0[0]); else n_pass++;
      n_checks++; if (got_r0[0] !== 16'hC3C3) $display("FAIL midl_r: got %h want c3c3", got_r0[0]); else n_pass++;
    end
    n_checks++; if (ovf0 !== 1'b0) $display("FAIL midl_ovf: got %b want 0", ovf0); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    set_ready(1'b0);
    send_part(1'b1, 5);
    send_word(1'b0, 70'h0BAD_F00D, 32, 0);
    send_word(1'b1, 70'h600D_CAFE, 32, 0);
    send_part(1'b0, 10);
    n_checks++; if (valid0 !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", valid0); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (l0 !== 16'h0) $display("FAIL rst_async_l: got %h want 0000", l0); else n_pass++;
    n_checks++; if (r0 !== 16'h0) $display("FAIL rst_async_r: got %h want 0000", r0); else n_pass++;
    n_checks++; if (valid0 !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", valid0); else n_pass++;
    repeat (3) @(negedge clk);
    clear_monitors();
    rst_n = 1'b1;
    set_ready(1'b1);
    send_part(1'b0, 12);
    send_word(1'b1, 70'h1111_1111, 32, 0);
    send_word(1'b0, 70'hFACE_0000, 32, 0);
    send_word(1'b1, 70'hD00D_0000, 32, 0);
    send_part(1'b0, 4);
    repeat (8) @(negedge clk);
    n_checks++; if (got_l0.size() !== 1) $display("FAIL rst_post_count: got %0d want 1", got_l0.size()); else n_pass++;
    if (got_l0.size() > 0) begin
      n_checks++; if (got_l0[0] !== 16'hFACE) $display("FAIL rst_post_l: got %h want face", got_l0[0]); else n_pass++;
      n_checks++; if (got_r0[0] !== 16'hD00D) $display("FAIL rst_post_r: got %h want d00d", got_r0[0]); else n_pass++;
    end
  endtask

  task automatic test_long_slots();
    do_reset();
    set_ready(1'b1);
    send_word(1'b1, 70'h0, 70, 0);
    send_word(1'b0, {32'hDEAD_BEEF, 38'h15_5555_5555}, 70, 0);
    send_word(1'b1, {32'h0F1E_2D3C, 38'h15_5555_5555}, 70, 0);
    send_word(1'b0, {32'h1357_9BDF, 38'h15_5555_5555}, 70, 0);
    send_word(1'b1, {32'h2468_ACE0, 38'h15_5555_5555}, 70, 0);
    send_part(1'b0, 4);
    repeat (8) @(negedge clk);
    n_checks++; if (got_l2.size() !== 2) $display("FAIL long_count: got %0d want 2", got_l2.size()); else n_pass++;
    if (got_l2.size() > 1) begin
      n_checks++; if (got_l2[0] !== 32'hDEADBEEF) $display("FAIL long_l0: got %h want deadbeef", got_l2[0]); else n_pass++;
      n_checks++; if (got_r2[0] !== 32'h0F1E2D3C) $display("FAIL long_r0: got %h want 0f1e2d3c", got_r2[0]); else n_pass++;
      n_checks++; if (got_l2[1] !== 32'h13579BDF) $display("FAIL long_l1: got %h want 13579bdf", got_l2[1]); else n_pass++;
      n_checks++; if (got_r2[1] !== 32'h2468ACE0) $display("FAIL long_r1: got %h want 2468ace0", got_r2[1]); else n_pass++;
    end
    n_checks++; if (ovf2 !== 1'b0) $display("FAIL long_ovf: got %b want 0", ovf2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_philips_basic();
    test_left_justified();
    test_overflow();
    test_mid_stream();
    test_reset_mid_word();
    test_long_slots();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
